// File: rtl/bcd_down_counter.sv
// Multi-digit synchronous BCD down-counter with parallel load, registered borrow pulse and zero flag.
// Define BCD_DOWN_LOAD_CHECK_EN to add the sticky err output that flags loads with non-BCD digits.
module bcd_down_counter #(
   parameter int DIGITS = 4,
   parameter bit WRAP   = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic [4*DIGITS-1:0] din,
   input  logic                en,
   output logic [4*DIGITS-1:0] dout,
   output logic                borrow,
`ifdef BCD_DOWN_LOAD_CHECK_EN
   output logic                err,
`endif
   output logic                zero
);

   localparam int DATA_W = 4 * DIGITS;

   // Force every digit above 9 down to 9 so the count never holds a non-BCD digit.
   function automatic logic [DATA_W-1:0] clamp_bcd(input logic [DATA_W-1:0] v);
      logic [DATA_W-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
      end
      return r;
   endfunction

   function automatic logic has_bad_digit(input logic [DATA_W-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction

   // Returns {borrow_out, value-1}; borrow_out is set only when the input was all zeros,
   // in which case the value naturally comes back as all nines.
   function automatic logic [DATA_W:0] bcd_decrement(input logic [DATA_W-1:0] v);
      logic [DATA_W-1:0] r;
      logic              chain;
      r     = v;
      chain = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (chain) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               chain       = 1'b0;
            end
         end
      end
      return {chain, r};
   endfunction

   logic [DATA_W-1:0] dec_value;
   logic              dec_from_zero;
   logic [DATA_W-1:0] load_value;
   logic              load_bad;

   always_comb begin
      {dec_from_zero, dec_value} = bcd_decrement(dout);
      load_value                 = clamp_bcd(din);
      load_bad                   = has_bad_digit(din);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dout   <= '0;
         borrow <= 1'b0;
      end else if (load) begin
         dout   <= load_value;
         borrow <= 1'b0;
      end else if (en) begin
         // Underflow: wrap to all nines or pin at zero, but always report the borrow.
         if (dec_from_zero) begin
            dout   <= WRAP ? dec_value : '0;
            borrow <= 1'b1;
         end else begin
            dout   <= dec_value;
            borrow <= 1'b0;
         end
      end else begin
         borrow <= 1'b0;
      end
   end

`ifdef BCD_DOWN_LOAD_CHECK_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         err <= 1'b0;
      end else if (load) begin
         err <= load_bad;
      end
   end
`else
   logic unused_load_bad;
   assign unused_load_bad = load_bad;
`endif

   assign zero = (dout == '0);

endmodule

// File: tb/tb_bcd_down_counter.sv
// Scoreboard bench for bcd_down_counter: WRAP=1 and WRAP=0 instances driven in parallel,
// checked against an integer-valued reference model.
module tb_bcd_down_counter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic [15:0] din = '0;
   logic        en = 1'b0;

   logic [15:0] dout_w, dout_h;
   logic        borrow_w, borrow_h, zero_w, zero_h;
`ifdef BCD_DOWN_LOAD_CHECK_EN
   logic        err_w, err_h;
`endif

   always #5 clk = ~clk;

   bcd_down_counter #(.DIGITS(4), .WRAP(1'b1)) dut_wrap (
      .clk(clk), .reset(reset), .load(load), .din(din), .en(en),
      .dout(dout_w), .borrow(borrow_w),
`ifdef BCD_DOWN_LOAD_CHECK_EN
      .err(err_w),
`endif
      .zero(zero_w)
   );

   bcd_down_counter #(.DIGITS(4), .WRAP(1'b0)) dut_hold (
      .clk(clk), .reset(reset), .load(load), .din(din), .en(en),
      .dout(dout_h), .borrow(borrow_h),
`ifdef BCD_DOWN_LOAD_CHECK_EN
      .err(err_h),
`endif
      .zero(zero_h)
   );

   typedef struct {
      logic [15:0] dout_w;
      logic        borrow_w;
      logic        zero_w;
      logic [15:0] dout_h;
      logic        borrow_h;
      logic        zero_h;
      logic        err;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model state: plain integer counts.
   int   val_w = 0, val_h = 0;
   logic bor_w = 1'b0, bor_h = 1'b0, err_m = 1'b0;

   function automatic int bcd_to_int_clamped(input logic [15:0] d);
      int v, dg;
      v = 0;
      for (int i = 3; i >= 0; i--) begin
         dg = int'(d[4*i +: 4]);
         if (dg > 9) dg = 9;
         v = v * 10 + dg;
      end
      return v;
   endfunction

   function automatic logic any_invalid(input logic [15:0] d);
      for (int i = 0; i < 4; i++) if (d[4*i +: 4] > 4'd9) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [15:0] int_to_bcd(input int v);
      logic [15:0] r;
      int          t;
      t = v;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp_v, $time);
      end
   endtask

   task automatic step(input logic r, input logic l, input logic [15:0] d, input logic e);
      exp_t x;
      @(negedge clk);
      reset = r; load = l; din = d; en = e;
      if (r) begin
         val_w = 0; val_h = 0; bor_w = 0; bor_h = 0; err_m = 0;
      end else if (l) begin
         val_w = bcd_to_int_clamped(d);
         val_h = val_w;
         bor_w = 0; bor_h = 0;
         err_m = any_invalid(d);
      end else if (e) begin
         bor_w = (val_w == 0);
         val_w = (val_w == 0) ? 9999 : val_w - 1;
         bor_h = (val_h == 0);
         val_h = (val_h == 0) ? 0 : val_h - 1;
      end else begin
         bor_w = 0; bor_h = 0;
      end
      x.dout_w = int_to_bcd(val_w); x.borrow_w = bor_w; x.zero_w = (val_w == 0);
      x.dout_h = int_to_bcd(val_h); x.borrow_h = bor_h; x.zero_h = (val_h == 0);
      x.err    = err_m;
      q.push_back(x);
   endtask

   // Monitor: every clock presents a new output word.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            x = q.pop_front();
            check("dout_wrap",   dout_w,          x.dout_w);
            check("borrow_wrap", {15'd0, borrow_w}, {15'd0, x.borrow_w});
            check("zero_wrap",   {15'd0, zero_w},   {15'd0, x.zero_w});
            check("dout_hold",   dout_h,          x.dout_h);
            check("borrow_hold", {15'd0, borrow_h}, {15'd0, x.borrow_h});
            check("zero_hold",   {15'd0, zero_h},   {15'd0, x.zero_h});
`ifdef BCD_DOWN_LOAD_CHECK_EN
            check("err_wrap",    {15'd0, err_w},    {15'd0, x.err});
            check("err_hold",    {15'd0, err_h},    {15'd0, x.err});
`endif
         end
      end
   end

   initial begin
      logic [15:0] rd;
      int          budget;
      // Reset state
      step(1, 0, 16'h0000, 0);
      step(1, 1, 16'h1234, 1);
      // Load 0100 then two decrements
      step(0, 1, 16'h0100, 0);
      step(0, 0, 16'h0000, 1);
      step(0, 0, 16'h0000, 1);
      step(0, 0, 16'h0000, 0);
      // Underflow: 0001 -> 0000 -> wrap/hold with borrow, then borrow drops
      step(0, 1, 16'h0001, 0);
      step(0, 0, 16'h0000, 1);
      step(0, 0, 16'h0000, 1);
      step(0, 0, 16'h0000, 0);
      // Hold instance: repeated from-zero decrements
      step(0, 1, 16'h0000, 0);
      step(0, 0, 16'h0000, 1);
      step(0, 0, 16'h0000, 1);
      step(0, 0, 16'h0000, 1);
      step(0, 0, 16'h0000, 0);
      // Load beats enable, reset beats load
      step(0, 1, 16'h0500, 1);
      step(1, 1, 16'h0500, 1);
      // Invalid digits clamp, then a clean load clears err
      step(0, 1, 16'h3A0F, 0);
      step(0, 0, 16'h0000, 1);
      step(0, 1, 16'h1234, 0);
      step(0, 1, 16'hFFFF, 1);
      step(0, 0, 16'h0000, 1);
      // Long ripple through every digit
      step(0, 1, 16'h1000, 0);
      step(0, 0, 16'h0000, 1);
      // Randomized traffic biased toward enable and small values
      for (int i = 0; i < 400; i++) begin
         rd = 16'($urandom);
         if ($urandom_range(0, 3) != 0) rd = int_to_bcd(int'($urandom_range(0, 12)));
         step(($urandom_range(0, 60) == 0), ($urandom_range(0, 9) == 0), rd,
              ($urandom_range(0, 4) != 0));
      end
      step(0, 0, 16'h0000, 0);
      budget = 0;
      while (q.size() > 0 && budget < 20) begin
         @(posedge clk);
         budget++;
      end
      #2;
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: actual=%0d pending required=0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
